// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    localparam int DMEM_DATA_W = 32;

    // An access faults when it is not word aligned or its word index lies outside the array.
    function automatic logic is_fault(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide RAM with synchronous write and registered read (read-before-write on the same index).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DMEM_DATA_W-1:0]   wd,
    output logic [DMEM_DATA_W-1:0]   rd
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing it would turn the RAM into a bank of flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
        rd <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port.
// Defining DMEM_STATS_EN adds saturating load_cnt/store_cnt completion counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
`ifdef DMEM_STATS_EN
    ,
    parameter int STATS_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [31:0]            addr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata,
    output logic                   ready,
    output logic                   busy,
`ifdef DMEM_STATS_EN
    output logic                   err,
    output logic [STATS_W-1:0]     load_cnt,
    output logic [STATS_W-1:0]     store_cnt
`else
    output logic                   err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_t            state;
    dmem_state_t            state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [DMEM_DATA_W-1:0] wdata_q;
    logic                   err_q;
    logic                   load_ok_q;
    logic [DMEM_DATA_W-1:0] rdata_q;
    logic [DMEM_DATA_W-1:0] rd;

    logic                   accept;
    logic                   commit;
    logic                   cur_we;
    logic [31:0]            cur_addr;
    logic [DMEM_DATA_W-1:0] cur_wdata;
    logic                   cur_fault;
    logic                   mem_we;

    // With LATENCY==1 the commit edge is the acceptance edge, so the live inputs are used directly.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        cur_we     = we_q;
        cur_addr   = addr_q;
        cur_wdata  = wdata_q;
        case (state)
            IDLE: begin
                cur_we    = we;
                cur_addr  = addr;
                cur_wdata = wdata;
                if (req) begin
                    accept     = 1'b1;
                    commit     = (LATENCY == 1);
                    state_next = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cur_fault = is_fault(cur_addr, DEPTH);
    assign mem_we    = commit && cur_we && !cur_fault && !reset;
    assign busy      = ((state == IDLE) && req) || (state == WAIT);
    assign ready     = (state == DONE);
    assign err       = (state == DONE) && err_q;
    // A good load's data arrives from the array's read register during DONE and is held afterwards.
    assign rdata     = ((state == DONE) && load_ok_q) ? rd : rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                err_q     <= cur_fault;
                load_ok_q <= !cur_we && !cur_fault;
                if (cur_fault) begin
                    rdata_q <= '0;
                end
            end
            if ((state == DONE) && load_ok_q) begin
                rdata_q <= rd;
            end
        end
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk(clk),
        .we (mem_we),
        .idx(cur_addr[IDX_W+1:2]),
        .wd (cur_wdata),
        .rd (rd)
    );

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else if ((state == DONE) && !err_q) begin
            if (we_q) begin
                if (store_cnt != '1) store_cnt <= store_cnt + STATS_W'(1);
            end else begin
                if (load_cnt != '1) load_cnt <= load_cnt + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 4) share the request bus; per-access cycle traces are checked.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rst1 = 1'b1, rst2 = 1'b1, rst4 = 1'b1;

    logic [31:0] rdata1, rdata2, rdata4;
    logic        ready1, ready2, ready4;
    logic        busy1, busy2, busy4;
    logic        err1, err2, err4;
`ifdef DMEM_STATS_EN
    logic [1:0]  lc1, sc1, lc2, sc2, lc4, sc4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Per-access traces: bit i = value in cycle i after the request cycle 0.
    logic [7:0]  bv1, bv2, bv4, rv1, rv2, rv4;
    logic [31:0] rd1, rd2, rd4;
    logic        er1, er2, er4;
    logic        seen;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(1)
`ifdef DMEM_STATS_EN
        , .STATS_W(2)
`endif
    ) u_l1 (
        .clk(clk), .reset(rst1), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .busy(busy1),
`ifdef DMEM_STATS_EN
        .err(err1), .load_cnt(lc1), .store_cnt(sc1)
`else
        .err(err1)
`endif
    );

    dmem_responder #(.DEPTH(64), .LATENCY(2)
`ifdef DMEM_STATS_EN
        , .STATS_W(2)
`endif
    ) u_l2 (
        .clk(clk), .reset(rst2), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .ready(ready2), .busy(busy2),
`ifdef DMEM_STATS_EN
        .err(err2), .load_cnt(lc2), .store_cnt(sc2)
`else
        .err(err2)
`endif
    );

    dmem_responder #(.DEPTH(64), .LATENCY(4)
`ifdef DMEM_STATS_EN
        , .STATS_W(2)
`endif
    ) u_l4 (
        .clk(clk), .reset(rst4), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .ready(ready4), .busy(busy4),
`ifdef DMEM_STATS_EN
        .err(err4), .load_cnt(lc4), .store_cnt(sc4)
`else
        .err(err4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request, then eight traced cycles; request fields are scrambled after acceptance.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        bv1 = '0; bv2 = '0; bv4 = '0; rv1 = '0; rv2 = '0; rv4 = '0;
        rd1 = 32'hBAD0BAD0; rd2 = 32'hBAD0BAD0; rd4 = 32'hBAD0BAD0;
        er1 = 1'bx; er2 = 1'bx; er4 = 1'bx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bv1[i] = busy1; bv2[i] = busy2; bv4[i] = busy4;
            rv1[i] = ready1; rv2[i] = ready2; rv4[i] = ready4;
            if (ready1) begin rd1 = rdata1; er1 = err1; end
            if (ready2) begin rd2 = rdata2; er2 = err2; end
            if (ready4) begin rd4 = rdata4; er4 = err4; end
            next_cycle();
            req = 1'b0; we = ~w; addr = 32'h0000_0004; wdata = 32'h5555_5555;
        end
        we = 1'b0; addr = '0; wdata = '0;
    endtask

    initial begin
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_rdata", rdata2, 32'h0);
        check("reset_ready", {29'h0, ready1, ready2, ready4}, 32'h0);
        check("reset_busy", {29'h0, busy1, busy2, busy4}, 32'h0);
        check("reset_err", {29'h0, err1, err2, err4}, 32'h0);
        next_cycle();
        rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
        next_cycle();

        // Store 0xDEADBEEF to 0x10: timing for each latency.
        run_req(1'b1, 32'h10, 32'hDEADBEEF);
        check("st_l2_busy", 32'(bv2), 32'h03);
        check("st_l2_ready", 32'(rv2), 32'h04);
        check("st_l2_err", 32'(er2), 32'h0);
        check("st_l2_rdata_held", rd2, 32'h0);
        check("st_l1_busy", 32'(bv1), 32'h01);
        check("st_l1_ready", 32'(rv1), 32'h02);
        check("st_l4_busy", 32'(bv4), 32'h0F);
        check("st_l4_ready", 32'(rv4), 32'h10);

        run_req(1'b0, 32'h10, 32'h0);
        check("ld10_l2_rdata", rd2, 32'hDEADBEEF);
        check("ld10_l2_err", 32'(er2), 32'h0);
        check("ld10_l4_rdata", rd4, 32'hDEADBEEF);

        // Store then load at 0x0; the store must leave rdata unchanged.
        run_req(1'b1, 32'h0, 32'h12345678);
        check("st0_l2_rdata_held", rd2, 32'hDEADBEEF);
        run_req(1'b0, 32'h0, 32'h0);
        check("ld0_l1_rdata", rd1, 32'h12345678);
        check("ld0_l1_ready", 32'(rv1), 32'h02);
        check("ld0_l1_busy", 32'(bv1), 32'h01);
        check("ld0_l1_err", 32'(er1), 32'h0);
        @(negedge clk);
        check("ld0_l1_rdata_hold", rdata1, 32'h12345678);
        next_cycle();

        // Misaligned store aliases word 4 but must not write it.
        run_req(1'b1, 32'h12, 32'hFFFFFFFF);
        check("mis_l2_err", 32'(er2), 32'h1);
        check("mis_l2_rdata", rd2, 32'h0);
        check("mis_l2_ready", 32'(rv2), 32'h04);
        check("mis_l1_err", 32'(er1), 32'h1);
        run_req(1'b0, 32'h10, 32'h0);
        check("mis_ld10_rdata", rd2, 32'hDEADBEEF);
        check("mis_ld10_err", 32'(er2), 32'h0);

        // Range boundary: word 64 faults, word 63 is valid.
        run_req(1'b0, 32'h100, 32'h0);
        check("oor_err", 32'(er2), 32'h1);
        check("oor_rdata", rd2, 32'h0);
        run_req(1'b1, 32'hFC, 32'hCAFEF00D);
        check("top_st_err", 32'(er2), 32'h0);
        run_req(1'b0, 32'hFC, 32'h0);
        check("top_ld_err", 32'(er2), 32'h0);
        check("top_ld_rdata", rd2, 32'hCAFEF00D);

        // Reset the LATENCY=4 responder while its store is in WAIT.
        run_req(1'b1, 32'h20, 32'h11111111);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5;
        next_cycle();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        next_cycle();
        rst4 = 1'b1;
        next_cycle();
        rst4 = 1'b0;
        @(negedge clk);
        check("rstw_ready", 32'(ready4), 32'h0);
        check("rstw_busy", 32'(busy4), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | ready4;
        end
        check("rstw_no_ready", 32'(seen), 32'h0);
        next_cycle();
        run_req(1'b0, 32'h20, 32'h0);
        check("rstw_l4_old", rd4, 32'h11111111);
        check("rstw_l4_err", 32'(er4), 32'h0);
        check("rstw_l2_new", rd2, 32'hA5A5A5A5);

`ifdef DMEM_STATS_EN
        rst2 = 1'b1;
        next_cycle();
        next_cycle();
        rst2 = 1'b0;
        @(negedge clk);
        check("stat_reset", {28'h0, lc2, sc2}, 32'h0);
        next_cycle();
        run_req(1'b0, 32'h10, 32'h0);
        run_req(1'b0, 32'h10, 32'h0);
        check("stat_ld2", 32'(lc2), 32'h2);
        run_req(1'b0, 32'h10, 32'h0);
        run_req(1'b0, 32'h10, 32'h0);
        run_req(1'b0, 32'h10, 32'h0);
        run_req(1'b0, 32'h101, 32'h0);
        check("stat_ld_sat", 32'(lc2), 32'h3);
        check("stat_st", 32'(sc2), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
